datapath_sequencer: RTL and testbench

//  Sequences the SRAM / registerFile / ALU datapath, replacing ad-hoc test FSMs.
//  On start it has two phases. LOAD copies NUM_DATA 16-bit words from SRAM into registers 0..NUM_DATA-1.

---
 rtl/dp_seq_pkg.sv | 34 +++
 rtl/datapath_sequencer_if.sv | 27 ++
 rtl/dp_seq_addr_gen.sv | 41 ++++
 rtl/datapath_sequencer.sv | 123 ++++++++++++
 tb/tb_datapath_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_seq_pkg.sv
// rtl/dp_seq_pkg.sv - shared types and constants for the datapath sequencer
package dp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_ADDR,
    LD_WR,
    BRK,
    EX_FETCH,
    EX_DEC,
    EX_WB,
    DONE
  } state_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [2:0] op;
  } instr_t;

  // Instruction fields actually held by the sequencer; the reserved bits are dropped at fetch.
  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] rs;
    logic [2:0] op;
  } dec_t;

  localparam int FLAG_NEG   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 3;

endpackage

// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - SRAM / register file / ALU bus driven by the sequencer
interface datapath_sequencer_if;
  logic [15:0] sram_rdata;
  logic [10:0] sram_addr;
  logic        sram_oe_n;
  logic        sram_wr_n;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wr_en;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [2:0]  alu_ctrl;

  modport master (
    input  sram_rdata, alu_result, alu_flags,
    output sram_addr, sram_oe_n, sram_wr_n, rf_raddr1, rf_raddr2,
           rf_waddr, rf_wdata, rf_wr_en, alu_ctrl
  );

  modport slave (
    output sram_rdata, alu_result, alu_flags,
    input  sram_addr, sram_oe_n, sram_wr_n, rf_raddr1, rf_raddr2,
           rf_waddr, rf_wdata, rf_wr_en, alu_ctrl
  );
endinterface

// File: rtl/dp_seq_addr_gen.sv
// rtl/dp_seq_addr_gen.sv - shared item counter with base-add address outputs and last-item flag
module dp_seq_addr_gen #(
  parameter int          NUM_DATA   = 16,
  parameter int          NUM_OPS    = 8,
  parameter logic [10:0] DATA_BASE  = 11'd0,
  parameter logic [10:0] INSTR_BASE = 11'd16,
  parameter logic [4:0]  DST_BASE   = 5'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  input  logic        exec_phase,
  output logic [10:0] sram_addr,
  output logic [4:0]  cnt,
  output logic [4:0]  dst_waddr,
  output logic        last
);
  import dp_seq_pkg::*;

  logic [4:0] cnt_q, cnt_d;
  logic [5:0] last_idx;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  // Six-bit compare so a count of 32 terminates at index 31 without wrapping the counter.
  assign last_idx  = exec_phase ? 6'(NUM_OPS - 1) : 6'(NUM_DATA - 1);
  assign last      = ({1'b0, cnt_q} == last_idx);
  assign sram_addr = (exec_phase ? INSTR_BASE : DATA_BASE) + {6'b0, cnt_q};
  assign cnt       = cnt_q;
  assign dst_waddr = DST_BASE + cnt_q;
endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - LOAD / breakpoint / EXEC sequencer for the SRAM, register file and ALU
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int          NUM_DATA   = 16,
  parameter int          NUM_OPS    = 8,
  parameter logic [10:0] DATA_BASE  = 11'd0,
  parameter logic [10:0] INSTR_BASE = 11'd16,
  parameter logic [4:0]  DST_BASE   = 5'd16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        step_en,
  datapath_sequencer_if.master        dp,
  output logic [3:0]                  flags,
  output logic                        busy,
  output logic                        done
);

  state_t      state_q, state_d;
  dec_t        instr_q, instr_d;
  logic [3:0]  flags_q, flags_d;
  logic        cnt_clr, cnt_inc, exec_phase, last;
  logic [10:0] gen_addr;
  logic [4:0]  cnt, dst_waddr;

  dp_seq_addr_gen #(
    .NUM_DATA(NUM_DATA), .NUM_OPS(NUM_OPS), .DATA_BASE(DATA_BASE),
    .INSTR_BASE(INSTR_BASE), .DST_BASE(DST_BASE)
  ) u_addr_gen (
    .clk(clk), .reset(reset), .clr(cnt_clr), .inc(cnt_inc), .exec_phase(exec_phase),
    .sram_addr(gen_addr), .cnt(cnt), .dst_waddr(dst_waddr), .last(last)
  );

  assign exec_phase = state_q inside {EX_FETCH, EX_DEC, EX_WB};

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    flags_d = flags_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE:     if (start) begin state_d = LD_ADDR; cnt_clr = 1'b1; end
      LD_ADDR:  state_d = LD_WR;
      LD_WR: begin
        if (last) begin state_d = BRK; cnt_clr = 1'b1; end
        else begin state_d = LD_ADDR; cnt_inc = 1'b1; end
      end
      BRK:      if (step_en) state_d = EX_FETCH;
      EX_FETCH: begin instr_d = dec_t'(dp.sram_rdata[12:0]); state_d = EX_DEC; end
      EX_DEC:   state_d = EX_WB;
      EX_WB: begin
        flags_d = dp.alu_flags;
        if (last) begin state_d = DONE; cnt_clr = 1'b1; end
        else begin state_d = EX_FETCH; cnt_inc = 1'b1; end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Abort overrides; the write already presented this cycle still lands on this edge.
    if (abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    dp.sram_addr = '0;
    dp.sram_oe_n = 1'b1;
    dp.rf_raddr1 = '0;
    dp.rf_raddr2 = '0;
    dp.rf_waddr  = '0;
    dp.rf_wdata  = '0;
    dp.rf_wr_en  = 1'b0;
    dp.alu_ctrl  = '0;
    case (state_q)
      LD_ADDR, EX_FETCH: begin
        dp.sram_addr = gen_addr;
        dp.sram_oe_n = 1'b0;
      end
      LD_WR: begin
        dp.sram_addr = gen_addr;
        dp.sram_oe_n = 1'b0;
        dp.rf_waddr  = cnt;
        dp.rf_wdata  = {16'b0, dp.sram_rdata};
        dp.rf_wr_en  = 1'b1;
      end
      EX_DEC, EX_WB: begin
        dp.rf_raddr1 = instr_q.rs;
        dp.rf_raddr2 = instr_q.rt;
        dp.alu_ctrl  = instr_q.op;
        if (state_q == EX_WB) begin
          dp.rf_waddr = dst_waddr;
          dp.rf_wdata = dp.alu_result;
          dp.rf_wr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dp.sram_wr_n = 1'b1;
  assign flags        = flags_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - directed bench with SRAM, register file and ALU models around two sequencers
module tb_datapath_sequencer;
  import dp_seq_pkg::*;

  logic clk, reset, start, start_b, abort, step_en;
  logic [3:0] flags_a, flags_b;
  logic busy_a, busy_b, done_a, done_b;

  datapath_sequencer_if ifa();
  datapath_sequencer_if ifb();

  datapath_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .step_en(step_en),
    .dp(ifa), .flags(flags_a), .busy(busy_a), .done(done_a)
  );

  datapath_sequencer #(
    .NUM_DATA(32), .NUM_OPS(4), .DATA_BASE(11'd100), .INSTR_BASE(11'd64), .DST_BASE(5'd30)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .step_en(step_en),
    .dp(ifb), .flags(flags_b), .busy(busy_b), .done(done_b)
  );

  logic [15:0] sram_a [2048];
  logic [15:0] sram_b [2048];
  logic [31:0] rf_a [32] = '{default: 32'd0};
  logic [31:0] rf_b [32] = '{default: 32'd0};
  int wr_cnt_a = 0;
  int wr_last_a = 0;
  int done_cnt_a = 0;

  function automatic logic [35:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic [3:0]  f;
    case (op)
      3'd0:    s = {1'b0, a & b};
      3'd1:    s = {1'b0, a | b};
      3'd2:    s = {1'b0, a} + {1'b0, b};
      3'd3:    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      default: s = {1'b0, a ^ b};
    endcase
    r = s[31:0];
    f = '0;
    f[FLAG_ZERO]  = (r == 32'd0);
    f[FLAG_CARRY] = s[32];
    f[FLAG_NEG]   = r[31];
    if (op == 3'd2) f[FLAG_OVF] = (a[31] == b[31]) && (r[31] != a[31]);
    else if (op == 3'd3) f[FLAG_OVF] = (a[31] != b[31]) && (r[31] != a[31]);
    return {f, r};
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i;
    i.rsvd = 3'b101;
    i.rt   = rt;
    i.rs   = rs;
    i.op   = op;
    return i;
  endfunction

  assign ifa.sram_rdata = sram_a[ifa.sram_addr];
  assign ifb.sram_rdata = sram_b[ifb.sram_addr];
  assign {ifa.alu_flags, ifa.alu_result} = alu(ifa.alu_ctrl, rf_a[ifa.rf_raddr1], rf_a[ifa.rf_raddr2]);
  assign {ifb.alu_flags, ifb.alu_result} = alu(ifb.alu_ctrl, rf_b[ifb.rf_raddr1], rf_b[ifb.rf_raddr2]);

  always @(posedge clk) begin
    if (ifa.rf_wr_en) begin
      rf_a[ifa.rf_waddr] <= ifa.rf_wdata;
      wr_cnt_a  <= wr_cnt_a + 1;
      wr_last_a <= int'(ifa.rf_waddr);
    end
    if (ifb.rf_wr_en) rf_b[ifb.rf_waddr] <= ifb.rf_wdata;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          dut;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel_b, input int limit, output int edges);
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < limit) begin
      tick();
      edges++;
      seen = sel_b ? done_b : done_a;
    end
  endtask

  task automatic apply_vecs(input int dut);
    foreach (vecs[k]) begin
      if (vecs[k].dut == dut)
        check($sformatf("rf%0d[%0d]", dut, vecs[k].idx),
              (dut == 0) ? rf_a[vecs[k].idx] : rf_b[vecs[k].idx], vecs[k].exp);
    end
  endtask

  initial begin
    int e;
    int base;
    int dbase;

    clk = 0; reset = 0; start = 0; start_b = 0; abort = 0; step_en = 1;

    for (int i = 0; i < 16; i++) sram_a[i] = 16'(i);
    for (int j = 0; j < 8; j++) sram_a[16 + j] = enc(3'd2, 5'(j), 5'(8 + j));
    for (int i = 0; i < 32; i++) sram_b[100 + i] = 16'(3 * i + 1);
    sram_b[64] = enc(3'd2, 5'd31, 5'd0);
    sram_b[65] = enc(3'd0, 5'd3, 5'd5);
    sram_b[66] = enc(3'd1, 5'd30, 5'd31);
    sram_b[67] = enc(3'd3, 5'd2, 5'd4);

    for (int i = 0; i < 16; i++) vecs.push_back('{0, i, 32'(i)});
    for (int j = 0; j < 8; j++) vecs.push_back('{0, 16 + j, 32'(2 * j + 8)});
    vecs.push_back('{1, 30, 32'd95});
    vecs.push_back('{1, 31, 32'd0});
    vecs.push_back('{1, 0, 32'd95});
    vecs.push_back('{1, 1, 32'hFFFF_FFFA});
    vecs.push_back('{1, 2, 32'd7});
    vecs.push_back('{1, 29, 32'd88});

    // reset state
    #3;
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_oe_n", {31'b0, ifa.sram_oe_n}, 32'd1);
    check("rst_wr_n", {31'b0, ifa.sram_wr_n}, 32'd1);
    check("rst_wr_en", {31'b0, ifa.rf_wr_en}, 32'd0);
    check("rst_addr", {21'b0, ifa.sram_addr}, 32'd0);
    check("rst_flags", {28'b0, flags_a}, 32'd0);
    check("rst_alu_ctrl", {29'b0, ifa.alu_ctrl}, 32'd0);
    tick(); tick();
    reset = 1;
    tick();

    // 1: normal run
    start = 1; tick(); start = 0;
    check("t1_ld_busy", {31'b0, busy_a}, 32'd1);
    check("t1_ld_oe_n", {31'b0, ifa.sram_oe_n}, 32'd0);
    check("t1_ld_wr_en", {31'b0, ifa.rf_wr_en}, 32'd0);
    wait_done(1'b0, 200, e);
    check("t1_latency", e, 32'd57);
    check("t1_done_busy", {31'b0, busy_a}, 32'd1);
    tick();
    check("t1_done_pulse", {31'b0, done_a}, 32'd0);
    check("t1_idle_busy", {31'b0, busy_a}, 32'd0);
    apply_vecs(0);
    check("t1_flags", {28'b0, flags_a}, 32'd0);

    // 2: breakpoint holds between phases
    step_en = 0;
    start = 1; tick(); start = 0;
    repeat (32) tick();
    check("t2_brk_busy", {31'b0, busy_a}, 32'd1);
    check("t2_brk_wr_en", {31'b0, ifa.rf_wr_en}, 32'd0);
    check("t2_brk_oe_n", {31'b0, ifa.sram_oe_n}, 32'd1);
    repeat (20) tick();
    check("t2_park_wr_en", {31'b0, ifa.rf_wr_en}, 32'd0);
    step_en = 1;
    tick();
    check("t2_fetch_oe_n", {31'b0, ifa.sram_oe_n}, 32'd0);
    check("t2_fetch_addr", {21'b0, ifa.sram_addr}, 32'd16);
    wait_done(1'b0, 100, e);
    check("t2_latency", 53 + e, 32'd77);
    tick();

    // 3: abort in the fifth load write
    base = wr_cnt_a;
    dbase = done_cnt_a;
    start = 1; tick(); start = 0;
    repeat (9) tick();
    check("t3_ldwr_en", {31'b0, ifa.rf_wr_en}, 32'd1);
    check("t3_ldwr_addr", {27'b0, ifa.rf_waddr}, 32'd4);
    abort = 1; tick(); abort = 0;
    check("t3_abort_busy", {31'b0, busy_a}, 32'd0);
    repeat (5) tick();
    check("t3_writes", wr_cnt_a - base, 32'd5);
    check("t3_last_addr", wr_last_a, 32'd4);
    check("t3_no_done", done_cnt_a - dbase, 32'd0);
    abort = 1; start = 1; tick();
    check("t3_abort_start", {31'b0, busy_a}, 32'd0);
    abort = 0; start = 0;

    // 4: start held through the whole run
    start = 1; tick();
    wait_done(1'b0, 200, e);
    check("t4_latency", e, 32'd57);
    tick();
    check("t4_idle_gap", {31'b0, busy_a}, 32'd0);
    tick();
    check("t4_restart", {31'b0, busy_a}, 32'd1);
    abort = 1; start = 0; tick(); abort = 0;
    check("t4_cleanup", {31'b0, busy_a}, 32'd0);

    // 5: async reset in EX_DEC, then a clean run
    base = wr_cnt_a;
    start = 1; tick(); start = 0;
    repeat (34) tick();
    check("t5_dec_ctrl", {29'b0, ifa.alu_ctrl}, 32'd2);
    check("t5_dec_rs", {27'b0, ifa.rf_raddr1}, 32'd0);
    check("t5_dec_rt", {27'b0, ifa.rf_raddr2}, 32'd8);
    #2 reset = 0;
    #1;
    check("t5_rst_busy", {31'b0, busy_a}, 32'd0);
    check("t5_rst_ctrl", {29'b0, ifa.alu_ctrl}, 32'd0);
    check("t5_rst_rt", {27'b0, ifa.rf_raddr2}, 32'd0);
    check("t5_rst_oe_n", {31'b0, ifa.sram_oe_n}, 32'd1);
    check("t5_load_writes", wr_cnt_a - base, 32'd16);
    tick();
    reset = 1;
    tick();
    base = wr_cnt_a;
    start = 1; tick(); start = 0;
    wait_done(1'b0, 200, e);
    check("t5_latency", e, 32'd57);
    tick();
    check("t5_writes", wr_cnt_a - base, 32'd24);
    check("t5_rf23", rf_a[23], 32'd22);

    // 6: 32-word load, wrapping destination registers
    start_b = 1; tick(); start_b = 0;
    wait_done(1'b1, 200, e);
    check("t6_latency", e, 32'd77);
    tick();
    check("t6_idle_busy", {31'b0, busy_b}, 32'd0);
    apply_vecs(1);
    check("t6_flags", {28'b0, flags_b}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
